// File: rtl/netlist_stream_pkg.sv
// -----------------------------------------------------------------------------
// netlist_stream_pkg
//   Shared types for the placer netlist-record stream. Both the netlist writer
//   and the degree reader import this package.
//   Contents:
//     net_rec_t  - one (instance, pin, net) connection record plus last flag
//     deg_ent_t  - one per-net degree entry as seen by the net-weighting stage
//     rd_state_t - degree reader FSM encoding
//     sat_inc8   - saturating 8-bit increment used for pin totals
//   Struct field widths follow the default stream widths below.
// -----------------------------------------------------------------------------
package netlist_stream_pkg;

   localparam int unsigned NET_W_DEF  = 4;
   localparam int unsigned INST_W_DEF = 4;
   localparam int unsigned PIN_W_DEF  = 2;
   localparam int unsigned CNT_W_DEF  = 4;

   typedef struct packed {
      logic [INST_W_DEF-1:0] inst;
      logic [PIN_W_DEF-1:0]  pin;
      logic [NET_W_DEF-1:0]  net;
      logic                  last;
   } net_rec_t;

   typedef struct packed {
      logic [NET_W_DEF-1:0] net;
      logic [CNT_W_DEF-1:0] count;
      logic                 dangling;
      logic                 last;
   } deg_ent_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_EMIT
   } rd_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/degree_table.sv
// -----------------------------------------------------------------------------
// degree_table
//   2**NET_W x CNT_W register file holding per-net pin counts.
//   Ports:
//     clk       in  clock
//     clr_en    in  zero entry clr_addr this cycle (has priority over inc)
//     clr_addr  in  entry to clear
//     inc_en    in  saturating +1 on entry inc_addr
//     inc_addr  in  entry to increment
//     rd_addr   in  asynchronous read address
//     rd_data   out contents of entry rd_addr
//   No reset: contents are undefined until every entry has been cleared.
//   Increments land in the same edge they are requested, so back-to-back
//   increments of one entry both count without any forwarding.
// -----------------------------------------------------------------------------
module degree_table #(
   parameter int unsigned NET_W = 4,
   parameter int unsigned CNT_W = 4
) (
   input  logic             clk,
   input  logic             clr_en,
   input  logic [NET_W-1:0] clr_addr,
   input  logic             inc_en,
   input  logic [NET_W-1:0] inc_addr,
   input  logic [NET_W-1:0] rd_addr,
   output logic [CNT_W-1:0] rd_data
);

   localparam int unsigned DEPTH = 2**NET_W;

   logic [CNT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem[clr_addr] <= '0;
      end else if (inc_en && (mem[inc_addr] != '1)) begin
         mem[inc_addr] <= mem[inc_addr] + 1'b1;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/netlist_degree_reader.sv
// -----------------------------------------------------------------------------
// netlist_degree_reader
//   Consumes (instance, pin, net) connection records, builds a per-net pin
//   degree table and streams it out entry by entry, flagging dangling nets.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             1-cycle pulse, accepted only in IDLE
//     rec_valid/ready   record handshake (ready only in LOAD)
//     rec_inst/pin/net  record fields; inst used only for ordering check
//     rec_last          final record of the netlist
//     deg_valid/ready   degree entry handshake (valid only in EMIT)
//     deg_net/count     entry index and its saturated pin count
//     deg_dangling      entry count is exactly one
//     deg_last          entry for the highest net id
//     total_pins        accepted records, saturating at 255
//     err_sat/err_order sticky error flags, cleared by start
//     done              pulse the cycle after the final entry handshake
// -----------------------------------------------------------------------------
module netlist_degree_reader
   import netlist_stream_pkg::*;
#(
   parameter int unsigned NET_W  = 4,
   parameter int unsigned INST_W = 4,
   parameter int unsigned PIN_W  = 2,
   parameter int unsigned CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rec_valid,
   output logic              rec_ready,
   input  logic [INST_W-1:0] rec_inst,
   input  logic [PIN_W-1:0]  rec_pin,
   input  logic [NET_W-1:0]  rec_net,
   input  logic              rec_last,
   output logic              deg_valid,
   input  logic              deg_ready,
   output logic [NET_W-1:0]  deg_net,
   output logic [CNT_W-1:0]  deg_count,
   output logic              deg_dangling,
   output logic              deg_last,
   output logic [7:0]        total_pins,
   output logic              err_sat,
   output logic              err_order,
   output logic              done
);

   localparam logic [NET_W-1:0] IDX_MAX = '1;

   rd_state_t         state, state_nxt;
   logic [NET_W-1:0]  idx;
   logic [INST_W-1:0] prev_inst;
   logic              have_prev;
   logic              clr_en;
   logic              accept;
   logic [NET_W-1:0]  rd_addr;
   logic [CNT_W-1:0]  rd_data;

   // Pin index is carried on the stream but not needed for degree counting.
   logic unused_pin;
   assign unused_pin = ^rec_pin;

   assign accept = rec_valid & rec_ready;

   // Single read port: it looks up the incoming net during LOAD (for the
   // saturation check) and the walking index during EMIT.
   assign rd_addr = (state == ST_LOAD) ? rec_net : idx;

   degree_table #(
      .NET_W(NET_W),
      .CNT_W(CNT_W)
   ) u_table (
      .clk      (clk),
      .clr_en   (clr_en),
      .clr_addr (idx),
      .inc_en   (accept),
      .inc_addr (rec_net),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rec_ready = 1'b0;
      deg_valid = 1'b0;
      clr_en    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_CLEAR;
         end
         ST_CLEAR: begin
            clr_en = 1'b1;
            if (idx == IDX_MAX) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            rec_ready = 1'b1;
            if (rec_valid && rec_last) state_nxt = ST_EMIT;
         end
         ST_EMIT: begin
            deg_valid = 1'b1;
            if (deg_ready && (idx == IDX_MAX)) state_nxt = ST_IDLE;
         end
      endcase
   end

   // idx wraps from IDX_MAX back to zero at the end of CLEAR and EMIT, so it
   // is already zero when the next phase begins.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         prev_inst  <= '0;
         have_prev  <= 1'b0;
         total_pins <= '0;
         err_sat    <= 1'b0;
         err_order  <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (start) begin
                  idx        <= '0;
                  have_prev  <= 1'b0;
                  total_pins <= '0;
                  err_sat    <= 1'b0;
                  err_order  <= 1'b0;
               end
            end
            ST_CLEAR: begin
               idx <= idx + 1'b1;
            end
            ST_LOAD: begin
               if (accept) begin
                  total_pins <= sat_inc8(total_pins);
                  if (rd_data == '1) err_sat <= 1'b1;
                  if (have_prev && (rec_inst < prev_inst)) err_order <= 1'b1;
                  prev_inst <= rec_inst;
                  have_prev <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (deg_ready) begin
                  idx <= idx + 1'b1;
                  if (idx == IDX_MAX) done <= 1'b1;
               end
            end
         endcase
      end
   end

   assign deg_net      = idx;
   assign deg_count    = deg_valid ? rd_data : '0;
   assign deg_dangling = deg_valid && (rd_data == CNT_W'(1));
   assign deg_last     = deg_valid && (idx == IDX_MAX);

endmodule

// File: tb/tb_netlist_degree_reader.sv
// -----------------------------------------------------------------------------
// tb_netlist_degree_reader
//   Two readers share one record stream: dut_a with 4-bit counters and dut_b
//   with 2-bit counters, so saturation shows up on dut_b with short netlists.
// -----------------------------------------------------------------------------
module tb_netlist_degree_reader;

   logic       clk = 1'b0;
   logic       rst, start, rec_valid, rec_last, deg_ready;
   logic [3:0] rec_inst, rec_net;
   logic [1:0] rec_pin;

   logic       rec_ready_a, deg_valid_a, deg_dangling_a, deg_last_a;
   logic       err_sat_a, err_order_a, done_a;
   logic [3:0] deg_net_a, deg_count_a;
   logic [7:0] total_pins_a;

   logic       rec_ready_b, deg_valid_b, deg_dangling_b, deg_last_b;
   logic       err_sat_b, err_order_b, done_b;
   logic [3:0] deg_net_b;
   logic [1:0] deg_count_b;
   logic [7:0] total_pins_b;

   always #5 clk = ~clk;

   netlist_degree_reader #(.NET_W(4), .INST_W(4), .PIN_W(2), .CNT_W(4)) dut_a (
      .clk(clk), .rst(rst), .start(start),
      .rec_valid(rec_valid), .rec_ready(rec_ready_a), .rec_inst(rec_inst),
      .rec_pin(rec_pin), .rec_net(rec_net), .rec_last(rec_last),
      .deg_valid(deg_valid_a), .deg_ready(deg_ready), .deg_net(deg_net_a),
      .deg_count(deg_count_a), .deg_dangling(deg_dangling_a), .deg_last(deg_last_a),
      .total_pins(total_pins_a), .err_sat(err_sat_a), .err_order(err_order_a),
      .done(done_a)
   );

   netlist_degree_reader #(.NET_W(4), .INST_W(4), .PIN_W(2), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .start(start),
      .rec_valid(rec_valid), .rec_ready(rec_ready_b), .rec_inst(rec_inst),
      .rec_pin(rec_pin), .rec_net(rec_net), .rec_last(rec_last),
      .deg_valid(deg_valid_b), .deg_ready(deg_ready), .deg_net(deg_net_b),
      .deg_count(deg_count_b), .deg_dangling(deg_dangling_b), .deg_last(deg_last_b),
      .total_pins(total_pins_b), .err_sat(err_sat_b), .err_order(err_order_b),
      .done(done_b)
   );

   typedef struct {
      logic [3:0] inst;
      logic [1:0] pin;
      logic [3:0] net;
   } rec_t;

   typedef struct {
      logic [3:0] net;
      logic [3:0] count;
      logic       dangling;
      logic       last;
   } deg_t;

   // Testcase 6 netlist: net sequence and the hand-derived degree table.
   int   tc6_net [32];
   int   tc6_cnt [16];

   rec_t recs[$];
   deg_t qa[$], qb[$];

   int   tests = 0;
   int   fails = 0;
   int   done_a_cnt = 0;
   int   done_b_cnt = 0;
   bit   exp_sat_a, exp_sat_b, exp_order;

   bit         prev_stall = 1'b0;
   logic [3:0] held_net, held_cnt;
   logic       held_dang, held_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic sample();
      deg_t e;
      if (done_a) done_a_cnt++;
      if (done_b) done_b_cnt++;
      if (prev_stall) begin
         check("stall_net",  deg_net_a,      held_net);
         check("stall_cnt",  deg_count_a,    held_cnt);
         check("stall_dang", deg_dangling_a, held_dang);
         check("stall_last", deg_last_a,     held_last);
         check("stall_vld",  deg_valid_a,    1);
      end
      if (deg_valid_a && deg_ready) begin
         if (qa.size() == 0) check("sb_a_unexpected_entry", 1, 0);
         else begin
            e = qa.pop_front();
            check("a_net",  deg_net_a,      e.net);
            check("a_cnt",  deg_count_a,    e.count);
            check("a_dang", deg_dangling_a, e.dangling);
            check("a_last", deg_last_a,     e.last);
         end
      end
      if (deg_valid_b && deg_ready) begin
         if (qb.size() == 0) check("sb_b_unexpected_entry", 1, 0);
         else begin
            e = qb.pop_front();
            check("b_net",  deg_net_b,      e.net);
            check("b_cnt",  deg_count_b,    e.count);
            check("b_dang", deg_dangling_b, e.dangling);
            check("b_last", deg_last_b,     e.last);
         end
      end
      prev_stall = deg_valid_a && !deg_ready;
      held_net   = deg_net_a;
      held_cnt   = deg_count_a;
      held_dang  = deg_dangling_a;
      held_last  = deg_last_a;
   endtask

   task automatic tick();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   // Reference model: per-net counts saturating at 15 (dut_a) and 3 (dut_b).
   task automatic push_expect(input bit use_tc6);
      int   ca [16];
      int   cb [16];
      deg_t e;
      for (int n = 0; n < 16; n++) begin
         ca[n] = 0;
         cb[n] = 0;
      end
      exp_sat_a = 1'b0;
      exp_sat_b = 1'b0;
      exp_order = 1'b0;
      for (int i = 0; i < recs.size(); i++) begin
         if (ca[recs[i].net] == 15) exp_sat_a = 1'b1; else ca[recs[i].net]++;
         if (cb[recs[i].net] == 3)  exp_sat_b = 1'b1; else cb[recs[i].net]++;
         if (i > 0 && recs[i].inst < recs[i-1].inst) exp_order = 1'b1;
      end
      for (int n = 0; n < 16; n++) begin
         e.net      = 4'(n);
         e.last     = (n == 15);
         e.count    = use_tc6 ? 4'(tc6_cnt[n]) : 4'(ca[n]);
         e.dangling = (e.count == 4'd1);
         qa.push_back(e);
         e.count    = 4'(cb[n]);
         e.dangling = (cb[n] == 1);
         qb.push_back(e);
      end
   endtask

   task automatic run(input int abort_after, input bit toggle, input bit start_in_emit,
                      input bit use_tc6);
      int n;
      int d0a, d0b;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (!rec_ready_a && n < 40) begin
         tick();
         n++;
      end
      check("load_reached",    rec_ready_a,  1);
      check("clr_total_pins",  total_pins_a, 0);
      check("clr_err_sat",     err_sat_b,    0);
      check("clr_err_order",   err_order_a,  0);
      d0a = done_a_cnt;
      d0b = done_b_cnt;
      if (abort_after < 0) push_expect(use_tc6);
      for (int i = 0; i < recs.size(); i++) begin
         if (i == abort_after) begin
            rec_valid = 1'b0;
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check("rst_rec_ready",  rec_ready_a,  0);
            check("rst_deg_valid",  deg_valid_a,  0);
            check("rst_done",       done_a,       0);
            check("rst_total_pins", total_pins_a, 0);
            check("rst_err_order",  err_order_a,  0);
            for (int k = 0; k < 4; k++) tick();
            check("rst_no_done",    done_a_cnt - d0a, 0);
            check("rst_idle_ready", rec_ready_a,  0);
            return;
         end
         rec_valid = 1'b1;
         rec_inst  = recs[i].inst;
         rec_pin   = recs[i].pin;
         rec_net   = recs[i].net;
         rec_last  = (i == recs.size() - 1);
         n = 0;
         while (!rec_ready_a && n < 20) begin
            tick();
            n++;
         end
         if (n == 20) check("rec_accept_timeout", 0, 1);
         tick();
      end
      rec_valid = 1'b0;
      rec_last  = 1'b0;
      n = 0;
      while (done_a_cnt == d0a && n < 200) begin
         deg_ready = toggle ? ~deg_ready : 1'b1;
         start     = (start_in_emit && n == 3);
         tick();
         n++;
      end
      start     = 1'b0;
      deg_ready = 1'b1;
      for (int k = 0; k < 20; k++) tick();
      check("done_once_a",  done_a_cnt - d0a, 1);
      check("done_once_b",  done_b_cnt - d0b, 1);
      check("sb_a_drained", qa.size(), 0);
      check("sb_b_drained", qb.size(), 0);
      check("idle_ready",   rec_ready_a, 0);
      check("idle_valid",   deg_valid_a, 0);
      check("total_pins_a", total_pins_a, (recs.size() > 255) ? 255 : recs.size());
      check("total_pins_b", total_pins_b, (recs.size() > 255) ? 255 : recs.size());
      check("err_sat_a",    err_sat_a,   exp_sat_a);
      check("err_sat_b",    err_sat_b,   exp_sat_b);
      check("err_order_a",  err_order_a, exp_order);
      qa.delete();
      qb.delete();
   endtask

   task automatic load_tc6();
      rec_t r;
      recs.delete();
      for (int i = 0; i < 32; i++) begin
         r.inst = 4'((i * 13) / 32);
         r.pin  = 2'(i % 4);
         r.net  = 4'(tc6_net[i]);
         recs.push_back(r);
      end
   endtask

   initial begin
      rec_t r;
      tc6_net = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12,
                  4, 1, 2, 6, 7, 4, 0, 3, 5, 8, 9, 10, 11, 12,
                  1, 2, 4, 6, 7};
      tc6_cnt = '{2, 3, 3, 2, 4, 2, 3, 3, 2, 2, 2, 2, 2, 0, 0, 0};

      rst = 1'b1; start = 1'b0; rec_valid = 1'b0; rec_last = 1'b0;
      rec_inst = '0; rec_pin = '0; rec_net = '0; deg_ready = 1'b1;
      @(posedge clk); #1;
      tick(); tick();
      rst = 1'b0;
      check("reset_rec_ready",  rec_ready_a,  0);
      check("reset_deg_valid",  deg_valid_a,  0);
      check("reset_done",       done_a,       0);
      check("reset_total_pins", total_pins_a, 0);
      check("reset_err_sat",    err_sat_a,    0);
      check("reset_err_order",  err_order_a,  0);

      // 1: testcase 6 netlist, free-running downstream
      load_tc6();
      run(-1, 1'b0, 1'b0, 1'b1);

      // 2: eight back-to-back records to net 5
      recs.delete();
      for (int i = 0; i < 8; i++) begin
         r.inst = 4'(i); r.pin = 2'd0; r.net = 4'd5;
         recs.push_back(r);
      end
      run(-1, 1'b0, 1'b0, 1'b0);

      // 3: testcase 6 with deg_ready toggling every cycle
      load_tc6();
      deg_ready = 1'b0;
      run(-1, 1'b1, 1'b0, 1'b1);

      // 4: instance id goes backwards
      recs.delete();
      r.inst = 4'd3; r.pin = 2'd1; r.net = 4'd1; recs.push_back(r);
      r.inst = 4'd2; r.pin = 2'd0; r.net = 4'd2; recs.push_back(r);
      run(-1, 1'b0, 1'b0, 1'b0);

      // 5: reset mid-LOAD, then a clean testcase 6 run
      load_tc6();
      run(10, 1'b0, 1'b0, 1'b1);
      run(-1, 1'b0, 1'b0, 1'b1);

      // 6: start pulsed during EMIT is ignored
      run(-1, 1'b0, 1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
